// File: rtl/mc_ctrl_if.sv
// Control bus between the multicycle MIPS control unit (master) and the datapath (slave).
// The control unit consumes op/funct/zero and produces the ALU code, mux selects and strobes.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal_op;

    modport master (
        input  op, funct, zero,
        output alucontrol, alusrca, alusrcb, pcsrc, pcen, iord,
               memwrite, irwrite, regdst, memtoreg, regwrite, illegal_op
    );

    modport slave (
        output op, funct, zero,
        input  alucontrol, alusrca, alusrcb, pcsrc, pcen, iord,
               memwrite, irwrite, regdst, memtoreg, regwrite, illegal_op
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: Moore FSM with memory wait states (MEM_WAIT).
// Optional macro MC_CTRL_BNE_EN adds bne, sharing the BRANCH state with inverted zero test.
module mc_ctrl #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    state_t     state, state_d;
    logic [3:0] cnt, cnt_d;
    logic       last;
    logic       funct_ok;
    logic [2:0] funct_ctrl;

    function automatic logic is_mem(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

    always_comb begin
        funct_ok   = 1'b1;
        funct_ctrl = 3'b000;
        unique case (bus.funct)
            6'b100000: funct_ctrl = 3'b010;
            6'b100010: funct_ctrl = 3'b110;
            6'b100100: funct_ctrl = 3'b000;
            6'b100101: funct_ctrl = 3'b001;
            6'b000000: funct_ctrl = 3'b011;
            default:   funct_ok   = 1'b0;
        endcase
    end

`ifdef MC_CTRL_BNE_EN
    logic bne_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bne_q <= 1'b0;
        else if (state == S_DECODE)
            bne_q <= (bus.op == OP_BNE);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state;
        last            = (cnt == '0);
        bus.alucontrol  = 3'b000;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = 2'b00;
        bus.pcsrc       = 2'b00;
        bus.pcen        = 1'b0;
        bus.iord        = 1'b0;
        bus.memwrite    = 1'b0;
        bus.irwrite     = 1'b0;
        bus.regdst      = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.regwrite    = 1'b0;
        bus.illegal_op  = 1'b0;

        unique case (state)
            S_FETCH: begin
                bus.alusrcb    = 2'b01;
                bus.alucontrol = 3'b010;
                if (last) begin
                    bus.irwrite = 1'b1;
                    bus.pcen    = 1'b1;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.alusrcb    = 2'b11;
                bus.alucontrol = 3'b010;
                unique case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            state_d = S_EXECUTE;
                        end else begin
                            bus.illegal_op = 1'b1;
                            state_d        = S_FETCH;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:  state_d = S_BRANCH;
`endif
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_d        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.alucontrol = 3'b010;
                state_d        = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.iord = 1'b1;
                if (last)
                    state_d = S_MEMWB;
            end
            S_MEMWB: begin
                // Address stays on ALUOut through writeback so the read data is undisturbed.
                bus.iord     = 1'b1;
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.iord = 1'b1;
                if (last) begin
                    bus.memwrite = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_EXECUTE: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = funct_ctrl;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = 3'b110;
                bus.pcsrc      = 2'b01;
`ifdef MC_CTRL_BNE_EN
                bus.pcen       = bus.zero ^ bne_q;
`else
                bus.pcen       = bus.zero;
`endif
                state_d        = S_FETCH;
            end
            S_ADDIEX: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.alucontrol = 3'b010;
                state_d        = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.regwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                bus.pcsrc = 2'b10;
                bus.pcen  = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Counter only reloads on entry to a wait state; reset leaves it at 0,
        // so the first fetch after reset completes in a single cycle.
        cnt_d = cnt;
        if (is_mem(state) && !last)
            cnt_d = cnt - 4'd1;
        else if (is_mem(state_d))
            cnt_d = 4'(MEM_WAIT);
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: MEM_WAIT=0 and MEM_WAIT=2 instances, per-cycle output vectors.
module tb_mc_ctrl;
`ifdef MC_CTRL_BNE_EN
    localparam bit BNE = 1'b1;
`else
    localparam bit BNE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst0, rst2;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mc_ctrl_if bus0 ();
    mc_ctrl_if bus2 ();

    mc_ctrl #(.MEM_WAIT(0)) u0 (.clk(clk), .reset(rst0), .bus(bus0));
    mc_ctrl #(.MEM_WAIT(2)) u2 (.clk(clk), .reset(rst2), .bus(bus2));

    // {alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, illegal_op}
    logic [15:0] obs0, obs2;
    assign obs0 = {bus0.alucontrol, bus0.alusrca, bus0.alusrcb, bus0.pcsrc, bus0.pcen, bus0.iord,
                   bus0.memwrite, bus0.irwrite, bus0.regdst, bus0.memtoreg, bus0.regwrite, bus0.illegal_op};
    assign obs2 = {bus2.alucontrol, bus2.alusrca, bus2.alusrcb, bus2.pcsrc, bus2.pcen, bus2.iord,
                   bus2.memwrite, bus2.irwrite, bus2.regdst, bus2.memtoreg, bus2.regwrite, bus2.illegal_op};

    function automatic logic [15:0] mk(input logic [2:0] ac, input logic a, input logic [1:0] b,
                                       input logic [1:0] ps, input logic pcen, input logic iord,
                                       input logic mw, input logic irw, input logic rd,
                                       input logic m2r, input logic rw, input logic ill);
        return {ac, a, b, ps, pcen, iord, mw, irw, rd, m2r, rw, ill};
    endfunction

    typedef struct {
        string       tag;
        logic [15:0] v;
    } sb_t;
    sb_t sb[$];

    task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic push(input string name, input logic [15:0] v);
        sb_t e;
        e.tag = $sformatf("%s cyc%0d", name, sb.size() + 1);
        e.v   = v;
        sb.push_back(e);
    endtask

    function automatic logic [2:0] rtype_ctrl(input logic [5:0] f, output logic ok);
        ok = 1'b1;
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b000000: return 3'b011;
            default: begin
                ok = 1'b0;
                return 3'b000;
            end
        endcase
    endfunction

    // Expected per-cycle outputs of one instruction, written straight from the state descriptions.
    task automatic expect_instr(input int w, input logic [5:0] o, input logic [5:0] f,
                                input logic z, input bit first, input string name);
        logic [15:0] dec;
        logic        ok;
        logic [2:0]  ac;
        dec = mk(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        if (!first)
            for (int i = 0; i < w; i++) push(name, mk(3'b010, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        push(name, mk(3'b010, 0, 2'b01, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0));
        ac = rtype_ctrl(f, ok);
        case (o)
            6'b000000: begin
                if (ok) begin
                    push(name, dec);
                    push(name, mk(ac, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
                    push(name, mk(3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0));
                end else begin
                    push(name, dec | 16'h0001);
                end
            end
            6'b100011: begin
                push(name, dec);
                push(name, mk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
                for (int i = 0; i <= w; i++) push(name, mk(3'b000, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));
                push(name, mk(3'b000, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 1, 1, 0));
            end
            6'b101011: begin
                push(name, dec);
                push(name, mk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
                for (int i = 0; i < w; i++) push(name, mk(3'b000, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));
                push(name, mk(3'b000, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0));
            end
            6'b000100: begin
                push(name, dec);
                push(name, mk(3'b110, 1, 2'b00, 2'b01, z, 0, 0, 0, 0, 0, 0, 0));
            end
            6'b000101: begin
                if (BNE) begin
                    push(name, dec);
                    push(name, mk(3'b110, 1, 2'b00, 2'b01, ~z, 0, 0, 0, 0, 0, 0, 0));
                end else begin
                    push(name, dec | 16'h0001);
                end
            end
            6'b001000: begin
                push(name, dec);
                push(name, mk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
                push(name, mk(3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0));
            end
            6'b000010: begin
                push(name, dec);
                push(name, mk(3'b000, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0));
            end
            default: push(name, dec | 16'h0001);
        endcase
    endtask

    // Called at a negedge; drives the instruction and drains its expected vectors one per cycle.
    task automatic run_instr(input int d, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input bit first, input string name);
        sb_t e;
        if (d == 0) begin
            bus0.op = o; bus0.funct = f; bus0.zero = z;
        end else begin
            bus2.op = o; bus2.funct = f; bus2.zero = z;
        end
        expect_instr((d == 0) ? 0 : 2, o, f, z, first, name);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_vec(e.tag, (d == 0) ? obs0 : obs2, e.v);
            @(negedge clk);
        end
    endtask

    logic [15:0] f_last;

    initial begin
        f_last = mk(3'b010, 0, 2'b01, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0);
        rst0 = 1'b1;
        rst2 = 1'b1;
        bus0.op = 6'b100011; bus0.funct = '0; bus0.zero = 1'b0;
        bus2.op = 6'b100011; bus2.funct = '0; bus2.zero = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_vec($sformatf("reset0 c%0d", i), obs0, f_last);
            check_vec($sformatf("reset2 c%0d", i), obs2, f_last);
        end
        @(negedge clk);
        rst0 = 1'b0;

        run_instr(0, 6'b100011, 6'b000000, 1'b0, 1'b1, "lw_first");
        run_instr(0, 6'b100011, 6'b000000, 1'b0, 1'b0, "lw");
        run_instr(0, 6'b000000, 6'b100010, 1'b0, 1'b0, "sub");
        run_instr(0, 6'b000100, 6'b000000, 1'b1, 1'b0, "beq_z1");
        run_instr(0, 6'b000100, 6'b000000, 1'b0, 1'b0, "beq_z0");
        run_instr(0, 6'b001000, 6'b000000, 1'b0, 1'b0, "addi");
        run_instr(0, 6'b000010, 6'b000000, 1'b0, 1'b0, "j");
        run_instr(0, 6'b000000, 6'b100000, 1'b0, 1'b0, "add");
        run_instr(0, 6'b000000, 6'b100100, 1'b0, 1'b0, "and");
        run_instr(0, 6'b000000, 6'b100101, 1'b0, 1'b0, "or");
        run_instr(0, 6'b000000, 6'b000000, 1'b0, 1'b0, "sll");
        run_instr(0, 6'b101011, 6'b000000, 1'b0, 1'b0, "sw");
        run_instr(0, 6'b111111, 6'b000000, 1'b0, 1'b0, "ill_op");
        run_instr(0, 6'b000000, 6'b111000, 1'b0, 1'b0, "ill_funct");
        run_instr(0, 6'b000101, 6'b000000, 1'b0, 1'b0, "bne_z0");
        run_instr(0, 6'b000101, 6'b000000, 1'b1, 1'b0, "bne_z1");
        run_instr(0, 6'b001000, 6'b000000, 1'b0, 1'b0, "addi_after");

        // Abort a lw in MEMREAD with an asynchronous reset.
        bus0.op = 6'b100011;
        check_vec("abort fetch", obs0, f_last);
        @(negedge clk);
        check_vec("abort decode", obs0, mk(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check_vec("abort memadr", obs0, mk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check_vec("abort memread", obs0, mk(3'b000, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));
        rst0 = 1'b1;
        #1;
        check_vec("abort async", obs0, f_last);
        @(negedge clk);
        check_vec("abort held", obs0, f_last);
        rst0 = 1'b0;
        run_instr(0, 6'b000000, 6'b100010, 1'b0, 1'b1, "sub_after_abort");

        rst2 = 1'b0;
        run_instr(2, 6'b000010, 6'b000000, 1'b0, 1'b1, "w2_j_first");
        run_instr(2, 6'b101011, 6'b000000, 1'b0, 1'b0, "w2_sw");
        run_instr(2, 6'b100011, 6'b000000, 1'b0, 1'b0, "w2_lw");
        run_instr(2, 6'b000000, 6'b100000, 1'b0, 1'b0, "w2_add");
        run_instr(2, 6'b000100, 6'b000000, 1'b1, 1'b0, "w2_beq");
        run_instr(2, 6'b111111, 6'b000000, 1'b0, 1'b0, "w2_ill");
        run_instr(2, 6'b001000, 6'b000000, 1'b0, 1'b0, "w2_addi");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
